sw_state_seq: RTL

Parametrised switch-driven state sequencer; the successor of the two-state flip-flop plus next-state-logic toggle. It conditions a raw switch input (synchronise, optional debounce, rising-edge detect) and steps a NUM_STATES-state counter up or down on each press, with wrap or saturate behaviour and a hold input. It sits directly behind board switches and drives LEDs or downstream mode selects with both a binary and a one-hot state.

---
 rtl/sw_seq_pkg.sv | 19 +
 rtl/sw_debounce.sv | 72 +++++++
 rtl/sw_state_seq.sv | 91 +++++++++
 3 files changed

// File: rtl/sw_seq_pkg.sv
// +----------------------------------------------------------------------+
// | sw_seq_pkg : shared constants and helpers for the switch sequencer     |
// | Rev 1.0                                                                |
// +----------------------------------------------------------------------+
`default_nettype none

package sw_seq_pkg;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Width of a state index; never narrower than one bit.
  function automatic int state_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sw_debounce.sv
// +----------------------------------------------------------------------+
// | sw_debounce : switch synchroniser, optional filter and press detect    |
// | Filter present only when SW_DEBOUNCE_EN is defined.  Rev 1.0           |
// +----------------------------------------------------------------------+
`default_nettype none

module sw_debounce #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic sw,
  output logic filt,
  output logic press
);

  logic s0;
  logic s1;

  if (DEB_CYCLES < 1) begin : g_bad_deb
    $error("DEB_CYCLES must be at least 1");
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s0 <= 1'b0;
      s1 <= 1'b0;
    end else begin
      s0 <= sw;
      s1 <= s0;
    end
  end

`ifdef SW_DEBOUNCE_EN
  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic [CW-1:0] cnt;
  logic          cnt_done;

  assign cnt_done = (cnt == CW'(DEB_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt  <= '0;
      filt <= 1'b0;
    end else if (s1 == filt) begin
      cnt <= '0;
    end else if (cnt_done) begin
      cnt  <= '0;
      filt <= s1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Asserted in the cycle whose closing edge raises filt.
  assign press = s1 & ~filt & cnt_done;
`else
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      filt <= 1'b0;
    end else begin
      filt <= s1;
    end
  end

  assign press = s1 & ~filt;
`endif

endmodule

`default_nettype wire

// File: rtl/sw_state_seq.sv
// +----------------------------------------------------------------------+
// | sw_state_seq : switch-driven up/down state sequencer with decodes      |
// | Debounce filter enabled by SW_DEBOUNCE_EN.  Rev 1.0                    |
// +----------------------------------------------------------------------+
`default_nettype none

module sw_state_seq
  import sw_seq_pkg::*;
#(
  parameter int NUM_STATES = 2,
  parameter int DEB_CYCLES = 4,
  parameter int WRAP       = 1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 sw,
  input  logic                                 dir,
  input  logic                                 hold,
  output logic [state_width(NUM_STATES)-1:0]   state,
  output logic [NUM_STATES-1:0]                onehot,
  output logic                                 step,
  output logic                                 at_end
);

  localparam int          SW   = state_width(NUM_STATES);
  localparam logic [SW:0] LAST = (SW + 1)'(NUM_STATES - 1);

  logic        filt;
  logic        press;
  logic        advance;
  logic [SW:0] cur_ext;
  logic [SW:0] nxt_ext;

  if (NUM_STATES < 2) begin : g_bad_num
    $error("NUM_STATES must be at least 2");
  end

  sw_debounce #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_debounce (
    .clk   (clk),
    .reset (reset),
    .sw    (sw),
    .filt  (filt),
    .press (press)
  );

  assign cur_ext = {1'b0, state};

  // Extra headroom bit keeps the end-of-range compare exact for any NUM_STATES.
  always_comb begin
    nxt_ext = cur_ext;
    if (dir == DIR_UP) begin
      if (cur_ext >= LAST) begin
        nxt_ext = (WRAP != 0) ? '0 : cur_ext;
      end else begin
        nxt_ext = cur_ext + 1'b1;
      end
    end else begin
      if (cur_ext == '0) begin
        nxt_ext = (WRAP != 0) ? LAST : cur_ext;
      end else begin
        nxt_ext = cur_ext - 1'b1;
      end
    end
  end

  // A held or saturated press is swallowed: no state change and no step.
  assign advance = press & ~filt & ~hold & (nxt_ext != cur_ext);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= '0;
      step  <= 1'b0;
    end else begin
      step <= advance;
      if (advance) begin
        state <= nxt_ext[SW-1:0];
      end
    end
  end

  for (genvar i = 0; i < NUM_STATES; i++) begin : g_onehot
    assign onehot[i] = (cur_ext == (SW + 1)'(i));
  end

  assign at_end = (cur_ext == LAST);

endmodule

`default_nettype wire
